serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing D = A - B - Bin, LSB first, one bit per clock.
- It is the subtraction-direction counterpart of the parallel full adder in the Lab1 datapath.
- It trades area for latency and exposes a start/busy/done handshake so a sequencing FSM can drive it.
- It is used for difference/compare operations alongside the adder.

Parameters:
- N, default 4, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- A  input  N  minuend, sampled at accepted start.
- B  input  N  subtrahend, sampled at accepted start.
- Bin  input  1  borrow-in, sampled at accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse; D/Bout are valid from this cycle on.
- D  output  N  difference, mod 2^N.
- Bout  output  1  borrow-out: 1 iff A < B + Bin, all treated as unsigned.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE.
  - busy=0, done=0, D=0, Bout=0.
  - the internal shift registers and the bit counter are cleared.
  - reset mid-operation aborts the operation; no done is produced.
- States (IDLE, RUN, DONE):
  - IDLE: busy=0, done=0. If start=1, latch A, B and Bin into internal registers (borrow register <= Bin), clear the counter, and go to RUN.
  - RUN: busy=1. Each cycle:
    - take a = LSB of A register, b = LSB of B register, br = borrow register.
    - d = a ^ b ^ br.
    - br_next = (~a & b) | (~(a ^ b) & br).
    - shift A and B registers right by one.
    - shift d into the MSB of the work register, which shifts right.
    - counter increments.
    - after the Nth bit (counter = N-1), go to DONE.
  - In the same edge as the RUN -> DONE transition: D <= final work register and Bout <= final borrow, loaded together with the transition.
  - DONE: done=1, busy=0, lasts exactly one cycle.
    - If start=1 in DONE, it is accepted exactly as in IDLE: operands are latched and the next state is RUN.
    - Otherwise the next state is IDLE.
- Latency: start accepted at edge k; done is high in the cycle following edge k+N. For N=4, done rises 4 clocks after the accepting edge.
- D and Bout change only at the RUN -> DONE edge or on reset. They hold the last result through IDLE and through the next RUN.
- start while busy=1 is ignored; operands are not resampled.
- A, B and Bin may change freely after the accepting edge.
- Width rules:
  - counter width is $clog2(N).
  - all arithmetic is unsigned mod 2^N.
  - Bout is the true borrow of the N-bit operation.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - default width constant SUB_WIDTH=4.
- One natural combinational sub-module, full_subtractor_bit, with inputs a, b, bin and outputs d, bout. It implements the per-bit equations above and is instantiated once.
- FSM, counter and shift registers stay in serial_subtractor.

Test Plan (N=4, clk period 10 ns):
- Basic: rst for 2 cycles, then start with A=10, B=5, Bin=0 -> busy high 4 cycles; done pulses 1 cycle, 4 clocks after acceptance; D=5, Bout=0.
- Wrap/borrow: A=1, B=15, Bin=0 -> D=2, Bout=1. Then A=0, B=15, Bin=1 -> D=0, Bout=1.
- Borrow-in without underflow: A=6, B=1, Bin=1 -> D=4, Bout=0. Also A=15, B=15, Bin=0 -> D=0, Bout=0.
- Handshake:
  - Start A=10, B=5; at cycle 2 of RUN pulse start with A=3, B=9 -> ignored; result D=5.
  - Start held high through DONE with A=3, B=9 -> back-to-back run; next done gives D=10, Bout=1.
  - D stays 5 during the second RUN.
- Reset mid-operation: start A=12, B=3, then rst=1 at RUN cycle 2 -> next cycle busy=0, done=0, D=0, Bout=0; no done pulse within the following 10 cycles.
- Exhaustive self-check: all 512 (A, B, Bin) combinations, back-to-back, compared against a reference model of {Bout, D} = {1'b0, A} - B - Bin -> zero mismatches.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SUB_WIDTH = 4;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor D = A - B - Bin, LSB first, with start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = SUB_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         Bout
);

  localparam int CW = $clog2(N);

  state_t         state, state_nxt;
  logic [N-1:0]   a_sr, b_sr, w_sr;
  logic           br;
  logic [CW-1:0]  cnt;
  logic           d_bit, br_nxt, accept, last;

  full_subtractor_bit u_fsb (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_nxt)
  );

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DONE accepts a new start just like IDLE so a sequencer can chain operations.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      w_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      br   <= Bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      w_sr <= {d_bit, w_sr[N-1:1]};
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
      // Result registers are published only on the final bit so they hold through the next run.
      if (last) begin
        D    <= {d_bit, w_sr[N-1:1]};
        Bout <= br_nxt;
      end
    end
  end

endmodule
